// File: rtl/exc_dispatcher_pkg.sv
// Shared definitions for the CP0 exception dispatcher: exception codes,
// CP0 status bit positions and the dispatcher state encoding.
package exc_dispatcher_pkg;

  localparam logic [3:0] EXC_INT     = 4'h0;
  localparam logic [3:0] EXC_SYSCALL = 4'h8;
  localparam logic [3:0] EXC_BREAK   = 4'h9;
  localparam logic [3:0] EXC_TEQ     = 4'hD;

  localparam int ST_IE        = 0;
  localparam int ST_IM_SYSCALL = 1;
  localparam int ST_IM_BREAK  = 2;
  localparam int ST_IM_TEQ    = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HANDLER = 1'b1
  } disp_state_e;

endpackage

// File: rtl/exc_dispatcher_irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt line, followed by a
// third flop so a rising edge is seen as a single-cycle pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_async,
  output logic rise
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], irq_async};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  // sync_q[1] is the synchronized level, sync_q[2] its previous value
  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/exc_dispatcher.sv
// Initiator side of the CP0 exception interface: arbitrates decoder traps and
// external interrupts, raises a one-cycle request and redirects the PC.
//
//   state      | meaning
//   ST_IDLE    | normal execution, exceptions may be taken
//   ST_HANDLER | handler running, new exceptions blocked until eret
module exc_dispatcher
  import exc_dispatcher_pkg::*;
#(
  parameter int          N_IRQ      = 4,
  parameter logic [31:0] HANDLER_PC = 32'h0000_0004
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic             syscall_dec,
  input  logic             break_dec,
  input  logic             teq_dec,
  input  logic             teq_eq,
  input  logic             eret_dec,
  input  logic [31:0]      pc,
  input  logic [31:0]      status,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_en,
  output logic             exc_valid,
  output logic [3:0]       exc_code,
  output logic [31:0]      exc_epc,
  output logic             teq_exc,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             kill_wb,
  output logic             in_handler,
  output logic [N_IRQ-1:0] irq_pending,
  output logic             spurious_eret
);

  disp_state_e      state_q, state_d;
  logic [N_IRQ-1:0] irq_pending_q, irq_pending_d;
  logic             spurious_eret_q, spurious_eret_d;

  logic [N_IRQ-1:0] irq_rise;
  logic [N_IRQ-1:0] irq_masked;
  logic [N_IRQ-1:0] irq_sel;
  logic             irq_found;
  logic             ie;
  logic             teq_hit, brk_hit, sys_hit, irq_hit, sync_hit;
  logic             is_idle;
  logic             take;
  logic             take_irq;
  logic [3:0]       code;
  logic             unused_status;

  assign unused_status = ^status[31:4];

  for (genvar g = 0; g < N_IRQ; g++) begin : g_irq
    irq_sync_edge u_sync (
      .clk       (clk),
      .rst       (rst),
      .irq_async (irq_in[g]),
      .rise      (irq_rise[g])
    );
  end

  // Lowest enabled pending line wins among interrupts
  always_comb begin
    irq_masked = irq_pending_q & irq_en;
    irq_sel    = '0;
    irq_found  = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq_masked[i] && !irq_found) begin
        irq_sel[i] = 1'b1;
        irq_found  = 1'b1;
      end
    end
  end

  always_comb begin
    ie       = status[ST_IE];
    teq_hit  = teq_dec & teq_eq & ie & status[ST_IM_TEQ];
    brk_hit  = break_dec & ie & status[ST_IM_BREAK];
    sys_hit  = syscall_dec & ie & status[ST_IM_SYSCALL];
    irq_hit  = ie & (|irq_masked);
    sync_hit = teq_hit | brk_hit | sys_hit;
    is_idle  = (state_q == ST_IDLE);
    // Qualify with rst so every output is quiet during reset, even though
    // decoder-driven hits do not depend on any flop
    take     = ~rst & is_idle & instr_valid & (sync_hit | irq_hit);
    take_irq = take & ~sync_hit;

    if (teq_hit)      code = EXC_TEQ;
    else if (brk_hit) code = EXC_BREAK;
    else if (sys_hit) code = EXC_SYSCALL;
    else              code = EXC_INT;
  end

  always_comb begin
    state_d         = state_q;
    spurious_eret_d = spurious_eret_q;
    irq_pending_d   = (irq_pending_q & ~(take_irq ? irq_sel : '0)) | irq_rise;

    case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_HANDLER;
        else if (instr_valid && eret_dec) spurious_eret_d = 1'b1;
      end
      ST_HANDLER: begin
        if (instr_valid && eret_dec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      irq_pending_q   <= '0;
      spurious_eret_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      irq_pending_q   <= irq_pending_d;
      spurious_eret_q <= spurious_eret_d;
    end
  end

  assign exc_valid     = take;
  assign exc_code      = take ? code : 4'h0;
  assign exc_epc       = take ? pc : 32'h0;
  assign redirect      = take;
  assign redirect_pc   = rst ? 32'h0 : HANDLER_PC;
  assign kill_wb       = take;
  assign teq_exc       = ~rst & teq_dec & teq_eq;
  assign in_handler    = (state_q == ST_HANDLER);
  assign irq_pending   = irq_pending_q;
  assign spurious_eret = spurious_eret_q;

endmodule

// File: tb/tb_exc_dispatcher.sv
// Scoreboard bench for exc_dispatcher: each issued instruction pushes its
// expected response, which is popped and compared mid-cycle.
module tb_exc_dispatcher;

  localparam int N_IRQ = 4;
  localparam logic [31:0] HPC = 32'h0000_0004;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid, syscall_dec, break_dec, teq_dec, teq_eq, eret_dec;
  logic [31:0]      pc, status;
  logic [N_IRQ-1:0] irq_in, irq_en;
  logic             exc_valid, teq_exc, redirect, kill_wb, in_handler, spurious_eret;
  logic [3:0]       exc_code;
  logic [31:0]      exc_epc, redirect_pc;
  logic [N_IRQ-1:0] irq_pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic        ev;
    logic [3:0]  code;
    logic [31:0] epc;
    logic        teqx;
  } exp_t;

  exp_t sb[$];

  exc_dispatcher #(.N_IRQ(N_IRQ), .HANDLER_PC(HPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .syscall_dec   (syscall_dec),
    .break_dec     (break_dec),
    .teq_dec       (teq_dec),
    .teq_eq        (teq_eq),
    .eret_dec      (eret_dec),
    .pc            (pc),
    .status        (status),
    .irq_in        (irq_in),
    .irq_en        (irq_en),
    .exc_valid     (exc_valid),
    .exc_code      (exc_code),
    .exc_epc       (exc_epc),
    .teq_exc       (teq_exc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .kill_wb       (kill_wb),
    .in_handler    (in_handler),
    .irq_pending   (irq_pending),
    .spurious_eret (spurious_eret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_instr();
    instr_valid = 0; syscall_dec = 0; break_dec = 0;
    teq_dec = 0; teq_eq = 0; eret_dec = 0;
  endtask

  // Called just after a rising edge; drives one instruction for one cycle
  task automatic issue(input string tag, input logic sys, input logic brk,
                       input logic teq, input logic teqeq, input logic eret,
                       input logic [31:0] pcv, input logic ev, input logic [3:0] code);
    exp_t e;
    exp_t got;
    instr_valid = 1; syscall_dec = sys; break_dec = brk;
    teq_dec = teq; teq_eq = teqeq; eret_dec = eret; pc = pcv;
    e.tag = tag; e.ev = ev; e.code = code; e.epc = pcv; e.teqx = teq & teqeq;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({got.tag, "_valid"}, {31'd0, exc_valid}, {31'd0, got.ev});
      chk({got.tag, "_redir"}, {31'd0, redirect},  {31'd0, got.ev});
      chk({got.tag, "_kill"},  {31'd0, kill_wb},   {31'd0, got.ev});
      chk({got.tag, "_teqx"},  {31'd0, teq_exc},   {31'd0, got.teqx});
      if (got.ev) begin
        chk({got.tag, "_code"},  {28'd0, exc_code}, {28'd0, got.code});
        chk({got.tag, "_epc"},   exc_epc, got.epc);
        chk({got.tag, "_rpc"},   redirect_pc, HPC);
      end
    end
    @(posedge clk);
    #1;
    clear_instr();
  endtask

  initial begin
    rst = 1; clear_instr(); pc = 0; status = 0; irq_in = 0; irq_en = 0;
    tick(2);
    @(negedge clk);
    chk("rst_valid",   {31'd0, exc_valid},     32'd0);
    chk("rst_inh",     {31'd0, in_handler},    32'd0);
    chk("rst_pend",    {28'd0, irq_pending},   32'd0);
    chk("rst_spur",    {31'd0, spurious_eret}, 32'd0);
    rst = 0;
    tick(1);

    // Syscall taken, then blocked inside the handler
    status = 32'h3;
    issue("sys", 1, 0, 0, 0, 0, 32'h0040_0010, 1, 4'h8);
    chk("sys_inh", {31'd0, in_handler}, 32'd1);
    issue("sys_nest", 1, 0, 0, 0, 0, 32'h0040_0014, 0, 4'h0);
    chk("nest_inh", {31'd0, in_handler}, 32'd1);
    issue("eret1", 0, 0, 0, 0, 1, 32'h0040_0018, 0, 4'h0);
    chk("eret1_inh", {31'd0, in_handler}, 32'd0);
    chk("eret1_spur", {31'd0, spurious_eret}, 32'd0);

    // Priority and teq condition
    status = 32'hF;
    issue("brk_teq", 0, 1, 1, 1, 0, 32'h0000_0100, 1, 4'hD);
    issue("eret2", 0, 0, 0, 0, 1, 32'h0000_0104, 0, 4'h0);
    issue("teq_ne", 0, 0, 1, 0, 0, 32'h0000_0108, 0, 4'h0);
    issue("brk_sys", 1, 1, 0, 0, 0, 32'h0000_010C, 1, 4'h9);
    issue("eret3", 0, 0, 0, 0, 1, 32'h0000_0110, 0, 4'h0);
    status = 32'h1;
    issue("sys_masked", 1, 0, 0, 0, 0, 32'h0000_0114, 0, 4'h0);

    // Spurious eret is sticky
    issue("eret_idle", 0, 0, 0, 0, 1, 32'h0000_0118, 0, 4'h0);
    chk("spur_set", {31'd0, spurious_eret}, 32'd1);
    issue("plain", 0, 0, 0, 0, 0, 32'h0000_011C, 0, 4'h0);
    chk("spur_sticky", {31'd0, spurious_eret}, 32'd1);

    // IRQ line 2: pending appears on the third edge after the pulse
    irq_en = 4'hF;
    irq_in = 4'b0100;
    tick(1);
    irq_in = 4'b0000;
    tick(1);
    chk("irq2_edge2", {28'd0, irq_pending}, 32'h0);
    tick(1);
    chk("irq2_edge3", {28'd0, irq_pending}, 32'h4);
    issue("irq2", 0, 0, 0, 0, 0, 32'h0000_0200, 1, 4'h0);
    chk("irq2_clr", {28'd0, irq_pending}, 32'h0);
    chk("irq2_inh", {31'd0, in_handler}, 32'd1);
    issue("eret4", 0, 0, 0, 0, 1, 32'h0000_0204, 0, 4'h0);

    // Lines 0 and 3 held pending while IE=0, then served in index order
    status = 32'h0;
    irq_in = 4'b1001;
    tick(4);
    issue("ie_off", 0, 0, 0, 0, 0, 32'h0000_0300, 0, 4'h0);
    chk("pend_9", {28'd0, irq_pending}, 32'h9);
    status = 32'h1;
    issue("irq0", 0, 0, 0, 0, 0, 32'h0000_0304, 1, 4'h0);
    chk("pend_8", {28'd0, irq_pending}, 32'h8);
    issue("inh_hold", 0, 0, 0, 0, 0, 32'h0000_0308, 0, 4'h0);
    chk("pend_8_hold", {28'd0, irq_pending}, 32'h8);
    issue("eret5", 0, 0, 0, 0, 1, 32'h0000_030C, 0, 4'h0);
    issue("irq3", 0, 0, 0, 0, 0, 32'h0000_0310, 1, 4'h0);
    chk("pend_0", {28'd0, irq_pending}, 32'h0);
    issue("eret6", 0, 0, 0, 0, 1, 32'h0000_0314, 0, 4'h0);
    irq_in = 4'b0000;
    tick(4);

    // Asynchronous reset in the middle of a handler
    status = 32'h3;
    issue("sys2", 1, 0, 0, 0, 0, 32'h0000_0400, 1, 4'h8);
    irq_in = 4'b1010;
    tick(4);
    chk("pend_A", {28'd0, irq_pending}, 32'hA);
    chk("pre_rst_inh", {31'd0, in_handler}, 32'd1);
    instr_valid = 1; teq_dec = 1; teq_eq = 1; pc = 32'h0000_0500;
    #2;
    rst = 1;
    #1;
    chk("arst_inh",   {31'd0, in_handler},    32'd0);
    chk("arst_pend",  {28'd0, irq_pending},   32'd0);
    chk("arst_spur",  {31'd0, spurious_eret}, 32'd0);
    chk("arst_valid", {31'd0, exc_valid},     32'd0);
    chk("arst_teqx",  {31'd0, teq_exc},       32'd0);
    chk("arst_rpc",   redirect_pc,            32'd0);
    chk("arst_kill",  {31'd0, kill_wb},       32'd0);
    chk("arst_epc",   exc_epc,                32'd0);
    clear_instr();
    tick(2);

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
